dds_step_applier: RTL
=====================

# dds_step_applier

Consumer end of the phase-hold loop. Applies the one-cycle step_up/step_down pulses from the phase-lock controller to a bounded DDS frequency word, runs the DDS phase accumulator, and supplies the DDS table phase. Conditions the asynchronous comparator zero-crossing input and returns the captured accumulator phase to the controller as phase_strobe / phase_at_zc16. Sits in the 60 MHz domain between the lock controller and the DA lookup table.

## Interface
- ACC_W, 32, phase accumulator / addr_step width (≥17)
- STEP_INIT, 32'd21475, addr_step after reset
- STEP_MIN, 32'd1, lowest allowed addr_step
- STEP_MAX, 32'd4294967295 >> 2, highest allowed addr_step
- DEBOUNCE, 4, consecutive equal synced samples needed to change filtered ZC level (1..15)
- HOLDOFF, 16'd1000, min cycles between accepted ZC events
- TIMEOUT, 24'd6000000, cycles without accepted ZC before zc_lost asserts

- clk_60m  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- step_up_pulse  in  1  +1 addr_step request, one cycle
- step_down_pulse  in  1  −1 addr_step request, one cycle
- lock_en  in  1  1 = apply step pulses; 0 = ignore them
- zc_in  in  1  asynchronous comparator output
- addr_step  out  ACC_W  current frequency word
- dds_phase  out  16  acc[ACC_W-1:ACC_W-16], DA table address
- phase_strobe  out  1  one-cycle pulse per accepted rising ZC
- phase_at_zc16  out  16  phase captured at accepted ZC, valid with strobe, held until next
- step_sat  out  1  one-cycle pulse when a step request is refused at a bound
- zc_lost  out  1  level, high while no accepted ZC within TIMEOUT

## Operation
- Reset (rst=1 at edge): acc=0, addr_step=STEP_INIT, sync chain and filtered level=0, debounce count=0, holdoff count=0, timeout count=0; outputs phase_strobe=0, phase_at_zc16=0, step_sat=0, zc_lost=0, dds_phase=0. Reset mid-operation discards any in-flight edge.
- Step apply (lock_en=1): up only → addr_step+1 if addr_step<STEP_MAX, else unchanged and step_sat=1. Down only → addr_step−1 if addr_step>STEP_MIN, else unchanged and step_sat=1. Both in same cycle → no change, no step_sat. lock_en=0 → pulses ignored, no step_sat.
- Accumulator: acc <= acc + addr_step every cycle, modulo 2^ACC_W (natural wrap, no saturation). Uses the registered addr_step; an update becomes effective on the next accumulation.
- ZC conditioning: 2-FF synchronizer on zc_in. Debounce counter counts consecutive cycles where synced ≠ filtered; reaching DEBOUNCE flips filtered and clears counter; any cycle synced = filtered clears counter.
- Event FSM, states IDLE / HOLD:
  - IDLE: filtered rising edge → capture phase_at_zc16 = acc[ACC_W-1:ACC_W-16] (value in the edge-detect cycle), phase_strobe=1, load holdoff=HOLDOFF−1, clear timeout count, zc_lost=0, → HOLD.
  - HOLD: decrement holdoff each cycle; rising edges are dropped (no strobe, no capture); holdoff=0 → IDLE.
  - Falling edges never generate events.
- Timeout counter increments each cycle, saturating at TIMEOUT; on reaching TIMEOUT zc_lost=1; cleared only by an accepted event or reset.

## Timing
- zc_in rising (stable) → phase_strobe: 2 sync + DEBOUNCE + 1 cycles (7 at defaults).
- Step pulse at cycle n → addr_step updated at n+1 → first acc increment with new value at n+2.
- step_sat asserts in cycle n+1, width 1.
- phase_strobe width exactly 1; consecutive strobes separated by ≥HOLDOFF cycles.
- dds_phase is combinational from acc register (no extra latency).
- zc_lost rises TIMEOUT cycles after last accepted event (or after reset), falls in the strobe cycle.

## Test plan
- Reset then free-run 4 cycles with STEP_INIT=21475 → acc=85900, addr_step=21475, all pulse outputs 0.
- addr_step=STEP_MAX, step_up_pulse for 1 cycle → addr_step unchanged, step_sat one pulse; then step_down → addr_step=STEP_MAX−1, no step_sat; up+down together → no change.
- lock_en=0 with 10 up pulses → addr_step=STEP_INIT, step_sat never asserts.
- zc_in rises and stays high → phase_strobe exactly 7 cycles later, phase_at_zc16 = acc[31:16] of that cycle; 2-cycle glitch on zc_in → no strobe.
- Second clean rising edge 500 cycles after an accepted one (HOLDOFF=1000) → dropped; edge at 1200 cycles → accepted.
- No ZC for TIMEOUT=100 (test override) cycles → zc_lost=1 at cycle 100; next accepted edge clears it in the strobe cycle; assert rst mid-HOLD → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/dds_step_applier.sv
// DDS step applier: bounded frequency word, phase accumulator,
// comparator zero-crossing conditioning and phase capture.
module dds_step_applier #(
  parameter int unsigned          ACC_W     = 32,
  parameter logic [ACC_W-1:0]     STEP_INIT = ACC_W'(21475),
  parameter logic [ACC_W-1:0]     STEP_MIN  = ACC_W'(1),
  parameter logic [ACC_W-1:0]     STEP_MAX  = {2'b00, {(ACC_W-2){1'b1}}},
  parameter int unsigned          DEBOUNCE  = 4,
  parameter logic [15:0]          HOLDOFF   = 16'd1000,
  parameter logic [23:0]          TIMEOUT   = 24'd6000000
) (
  input  logic             i_clk_60m,
  input  logic             i_rst,
  input  logic             i_step_up_pulse,
  input  logic             i_step_down_pulse,
  input  logic             i_lock_en,
  input  logic             i_zc_in,
  output logic [ACC_W-1:0] o_addr_step,
  output logic [15:0]      o_dds_phase,
  output logic             o_phase_strobe,
  output logic [15:0]      o_phase_at_zc16,
  output logic             o_step_sat,
  output logic             o_zc_lost
);

  localparam logic [ACC_W-1:0] ONE     = ACC_W'(1);
  localparam logic [3:0]       DB_LAST = 4'(DEBOUNCE - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_step;
  logic             r_sat;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_filt;
  logic             r_filt_d;
  logic [3:0]       r_db_cnt;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_hold;
  logic [15:0]      w_hold_nxt;
  logic             r_strobe;
  logic             w_strobe_nxt;
  logic [15:0]      r_phase;
  logic [15:0]      w_phase_nxt;
  logic [23:0]      r_to_cnt;
  logic             w_up;
  logic             w_dn;
  logic             w_rise;

  assign w_up   = i_lock_en & i_step_up_pulse & ~i_step_down_pulse;
  assign w_dn   = i_lock_en & i_step_down_pulse & ~i_step_up_pulse;
  assign w_rise = r_filt & ~r_filt_d;

  // Frequency word: apply single step requests inside the bounds
  always_ff @(posedge i_clk_60m) begin
    if (i_rst) begin
      r_step <= STEP_INIT;
      r_sat  <= 1'b0;
    end else begin
      r_sat <= 1'b0;
      if (w_up) begin
        if (r_step < STEP_MAX) r_step <= r_step + ONE;
        else                   r_sat  <= 1'b1;
      end else if (w_dn) begin
        if (r_step > STEP_MIN) r_step <= r_step - ONE;
        else                   r_sat  <= 1'b1;
      end
    end
  end

  // Phase accumulator, wraps naturally
  always_ff @(posedge i_clk_60m) begin
    if (i_rst) r_acc <= '0;
    else       r_acc <= r_acc + r_step;
  end

  // Synchronizer, debounce filter and edge-detect delay
  always_ff @(posedge i_clk_60m) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1  <= i_zc_in;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      if (r_sync2 == r_filt) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_filt   <= ~r_filt;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 4'd1;
      end
    end
  end

  // Event FSM next state: accept rising edges outside holdoff
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_strobe_nxt = 1'b0;
    w_phase_nxt  = r_phase;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_strobe_nxt = 1'b1;
          w_phase_nxt  = r_acc[ACC_W-1 -: 16];
          w_hold_nxt   = HOLDOFF - 16'd1;
          w_state_nxt  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_hold == '0) w_state_nxt = S_IDLE;
        else              w_hold_nxt  = r_hold - 16'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Event FSM registers and captured phase
  always_ff @(posedge i_clk_60m) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_hold   <= '0;
      r_strobe <= 1'b0;
      r_phase  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_hold   <= w_hold_nxt;
      r_strobe <= w_strobe_nxt;
      r_phase  <= w_phase_nxt;
    end
  end

  // Loss-of-signal timer, cleared by each accepted event
  always_ff @(posedge i_clk_60m) begin
    if (i_rst)                r_to_cnt <= '0;
    else if (w_strobe_nxt)    r_to_cnt <= '0;
    else if (r_to_cnt != TIMEOUT) r_to_cnt <= r_to_cnt + 24'd1;
  end

  assign o_addr_step     = r_step;
  assign o_dds_phase     = r_acc[ACC_W-1 -: 16];
  assign o_phase_strobe  = r_strobe;
  assign o_phase_at_zc16 = r_phase;
  assign o_step_sat      = r_sat;
  assign o_zc_lost       = (r_to_cnt == TIMEOUT);

endmodule
